calc_sched: RTL and testbench
=============================

CALC_SCHED -- requirements
Module: calc_sched

Interface
REQ-001 SHALL have parameter RR_EN, default 1, meaning: 1 = round-robin arbitration; 0 = fixed priority with requester 0 highest.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, with reset synchronous and active-high.
REQ-004 SHALL have ports reqN_valid, input, 1, for N=0,1: requester N offers an operation.
REQ-005 SHALL have ports reqN_ready, output, 1: the operation from requester N is accepted this cycle.
REQ-006 SHALL have ports reqN_op, input, 2: opcode, where 00 = add, 01 = sub, 10 = mul, 11 = div.
REQ-007 SHALL have ports reqN_a and reqN_b, input, 4 each: operands.
REQ-008 SHALL have ports respN_valid, output, 1: a result is pending for requester N.
REQ-009 SHALL have ports respN_ready, input, 1: requester N consumes the result.
REQ-010 SHALL have ports respN_result, output, 4, and respN_carry, output, 1: the result bits.
REQ-011 SHALL have port busy, output, 1: asserted when the FSM is not in IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, EXEC, RESP with these transitions:
- IDLE->EXEC on any handshake.
- EXEC->RESP unconditionally.
- RESP->IDLE when respG_valid and respG_ready, where G is the granted requester.
REQ-013 SHALL, in IDLE, assert reqN_ready for at most one requester, combinationally from reqN_valid and the priority pointer; ready SHALL be 0 in EXEC and RESP.
REQ-014 SHALL arbitrate as follows when RR_EN=1 and both requesters are valid:
- Grant the requester not granted last.
- The pointer updates only on a handshake.
- After reset the pointer favours requester 0.
REQ-015 SHALL latch op, a, b and the grant index on handshake; requester inputs SHALL be ignored afterwards until the next IDLE.
REQ-016 SHALL, in EXEC, assert the core start strobe for exactly one cycle with the latched operands.
REQ-017 SHALL compute {carry,result} as the low 5 bits of the 4-bit operation:
- add: a+b.
- sub: a-b, two's complement, so carry is the borrow/sign bit.
- mul: a*b truncated to 5 bits.
- div: unsigned a/b, so carry=0.
REQ-018 SHALL return result=4'hF and carry=0 for div with b=0.
REQ-019 SHALL give a fixed latency: with the handshake in cycle T, respG_valid rises in cycle T+2.
REQ-020 SHALL hold respG_valid, result and carry stable until respG_ready; the non-granted resp_valid SHALL stay 0.
REQ-021 SHALL allow a same-cycle handshake: if respG_ready is already high in the first RESP cycle, the FSM returns to IDLE the next cycle, giving a minimum of 3 cycles per operation.
REQ-022 SHALL grant the back-to-back requester in the first IDLE cycle after RESP; no idle bubble beyond that cycle is permitted.

Reset
REQ-023 SHALL, with rst=1 at a clock edge, force:
- state=IDLE;
- all resp_valid, result, carry and busy to 0;
- the priority pointer to requester 0.
REQ-024 SHALL discard any in-flight operation when reset is asserted mid-operation (EXEC or RESP), delivering no response.
REQ-025 SHALL drive reqN_ready=0 during any cycle in which rst=1.

Configuration
REQ-026 SHALL, with CALC_SCHED_DIV0_ERR_EN defined, add an output respN_err (1 bit):
- It is 1 with respN_valid when the operation was div with b=0.
- It is 0 otherwise.
- It follows the same hold rules as result.
REQ-027 SHALL, without CALC_SCHED_DIV0_ERR_EN, omit the respN_err ports and logic; REQ-018 behaviour is unchanged.

Structure
REQ-028 SHALL define the following in package calc_pkg, shared with the datapath:
- opcode enum calc_op_e (ADD, SUB, MUL, DIV);
- FSM enum calc_sched_state_e;
- constant CALC_W=4;
- constant CALC_DIV0_RESULT=4'hF.
REQ-029 SHALL instantiate one sub-module, calc_core, which is the registered datapath loading {carry,result} on its start strobe; arbitration and FSM SHALL stay in calc_sched.

Verification
REQ-030 SHALL cover: req0 add a=9, b=8 -> resp0_valid at T+2, result=4'h1, carry=1.
REQ-031 SHALL cover: both valid at once, RR_EN=1, each re-requesting immediately -> grants 0,1,0,1; with RR_EN=0 -> grants 0,0,0.
REQ-032 SHALL cover: req1 sub a=3, b=5 -> result=4'hE, carry=1; mul a=15, b=15 -> result=4'h1, carry=0.
REQ-033 SHALL cover: div a=7, b=0 -> result=4'hF, carry=0; respN_err=1 only when the macro is defined.
REQ-034 SHALL cover: respN_ready held low 10 cycles -> respN_valid and result stable, reqN_ready=0 throughout, busy=1.
REQ-035 SHALL cover: rst pulsed in EXEC -> next cycle state IDLE, no resp_valid, and the following req0 served with the pointer at 0.

Source files
------------

// File: rtl/calc_sched_pkg.sv
// calc_pkg: shared opcode/FSM types and datapath constants for calc_sched and calc_core
package calc_pkg;
    localparam int CALC_W = 4;
    localparam logic [CALC_W-1:0] CALC_DIV0_RESULT = 4'hF;
    typedef enum logic [1:0] {ADD = 2'b00, SUB = 2'b01, MUL = 2'b10, DIV = 2'b11} calc_op_e;
    typedef enum logic [1:0] {IDLE, EXEC, RESP} calc_sched_state_e;
endpackage

// File: rtl/calc_sched_if.sv
// calc_sched_if: one requester's operation and response channel; CALC_SCHED_DIV0_ERR_EN adds err
interface calc_sched_if;
    import calc_pkg::*;
    logic valid, ready, resp_valid, resp_ready, carry;
    calc_op_e op;
    logic [CALC_W-1:0] a, b, result;
`ifdef CALC_SCHED_DIV0_ERR_EN
    logic err;
    modport master (output valid, op, a, b, resp_ready, input ready, resp_valid, result, carry, err);
    modport slave (input valid, op, a, b, resp_ready, output ready, resp_valid, result, carry, err);
`else
    modport master (output valid, op, a, b, resp_ready, input ready, resp_valid, result, carry);
    modport slave (input valid, op, a, b, resp_ready, output ready, resp_valid, result, carry);
`endif
endinterface

// File: rtl/calc_sched_core.sv
// calc_core: registered datapath loading {carry,result} on start; CALC_SCHED_DIV0_ERR_EN adds err
module calc_core
    import calc_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  calc_op_e          op,
    input  logic [CALC_W-1:0] a,
    input  logic [CALC_W-1:0] b,
    output logic [CALC_W-1:0] result,
    output logic              carry
`ifdef CALC_SCHED_DIV0_ERR_EN
    ,
    output logic              err
`endif
);
    logic [CALC_W:0] res_nx;
    logic div0;
    // low 5 bits of the selected operation; divide by zero saturates to CALC_DIV0_RESULT
    always_comb begin
        div0 = op == DIV && b == '0;
        res_nx = op == ADD ? {1'b0, a} + {1'b0, b}
               : op == SUB ? {1'b0, a} - {1'b0, b}
               : op == MUL ? {1'b0, a} * {1'b0, b}
               : div0 ? {1'b0, CALC_DIV0_RESULT} : {1'b0, a / b};
    end
    // load only on start so the result holds for the whole response phase
    always_ff @(posedge clk)
        if (rst) {carry, result} <= '0;
        else if (start) {carry, result} <= res_nx;
`ifdef CALC_SCHED_DIV0_ERR_EN
    // divide-by-zero flag follows the same load/hold timing as the result
    always_ff @(posedge clk)
        if (rst) err <= 1'b0;
        else if (start) err <= div0;
`endif
endmodule

// File: rtl/calc_sched.sv
// calc_sched: two-requester scheduler around calc_core; RR_EN picks round-robin or fixed priority; CALC_SCHED_DIV0_ERR_EN adds resp err
module calc_sched
    import calc_pkg::*;
#(
    parameter int RR_EN = 1
) (
    input  logic        clk,
    input  logic        rst,
    calc_sched_if.slave req0,
    calc_sched_if.slave req1,
    output logic        busy
);
    calc_sched_state_e state, state_nx;
    logic ptr, gnt, sel, hs, start, carry;
    calc_op_e op_q;
    logic [CALC_W-1:0] a_q, b_q, result;
`ifdef CALC_SCHED_DIV0_ERR_EN
    logic err;
`endif

    calc_core u_core (
        .clk, .rst, .start, .op(op_q), .a(a_q), .b(b_q), .result, .carry
`ifdef CALC_SCHED_DIV0_ERR_EN
        , .err
`endif
    );

    // pick a requester: ptr breaks ties in round-robin mode, otherwise requester 0 wins
    always_comb begin
        sel = (RR_EN != 0 && req0.valid && req1.valid) ? ptr : !req0.valid;
        hs = state == IDLE && !rst && (req0.valid || req1.valid);
    end

    // state register
    always_ff @(posedge clk)
        if (rst) state <= IDLE;
        else state <= state_nx;

    // next state: one EXEC cycle, then hold RESP until the granted requester consumes
    always_comb
        state_nx = state == IDLE ? (hs ? EXEC : IDLE)
                 : state == EXEC ? RESP
                 : ((gnt ? req1.resp_ready : req0.resp_ready) ? IDLE : RESP);

    // capture grant and operands on handshake; ptr then favours the other requester
    always_ff @(posedge clk)
        if (rst) begin
            ptr <= 1'b0;
            gnt <= 1'b0;
            op_q <= ADD;
            a_q <= '0;
            b_q <= '0;
        end else if (hs) begin
            ptr <= !sel;
            gnt <= sel;
            op_q <= sel ? req1.op : req0.op;
            a_q <= sel ? req1.a : req0.a;
            b_q <= sel ? req1.b : req0.b;
        end

    // outputs decoded from state and grant
    always_comb begin
        busy = state != IDLE;
        start = state == EXEC;
        req0.ready = hs && !sel;
        req1.ready = hs && sel;
        req0.resp_valid = state == RESP && !gnt;
        req1.resp_valid = state == RESP && gnt;
        req0.result = result;
        req1.result = result;
        req0.carry = carry;
        req1.carry = carry;
`ifdef CALC_SCHED_DIV0_ERR_EN
        req0.err = err;
        req1.err = err;
`endif
    end
endmodule

// File: tb/tb_calc_sched.sv
// tb_calc_sched: scoreboard bench for calc_sched (round-robin DUT plus a fixed-priority DUT)
module tb_calc_sched;
    import calc_pkg::*;

    typedef struct {int idx; int res; int car; int err; int hs;} exp_t;

    logic clk = 1'b0, rst = 1'b1, busy, busy_fp;
    logic [1:0] vld = 2'b00, rr = 2'b11, vf = 2'b00, pv = 2'b00;
    calc_op_e op_d[2];
    logic [3:0] a_d[2], b_d[2];
    int cyc = 0, total = 0, passed = 0;
    int vstart[2];
    exp_t sb[$];
    int gseq[$];

    calc_sched_if i0();
    calc_sched_if i1();
    calc_sched_if j0();
    calc_sched_if j1();

    assign i0.valid = vld[0];
    assign i0.op = op_d[0];
    assign i0.a = a_d[0];
    assign i0.b = b_d[0];
    assign i0.resp_ready = rr[0];
    assign i1.valid = vld[1];
    assign i1.op = op_d[1];
    assign i1.a = a_d[1];
    assign i1.b = b_d[1];
    assign i1.resp_ready = rr[1];
    assign j0.valid = vf[0];
    assign j0.op = ADD;
    assign j0.a = 4'd1;
    assign j0.b = 4'd2;
    assign j0.resp_ready = 1'b1;
    assign j1.valid = vf[1];
    assign j1.op = ADD;
    assign j1.a = 4'd3;
    assign j1.b = 4'd4;
    assign j1.resp_ready = 1'b1;

    wire [1:0] rdy = {i1.ready, i0.ready};
    wire [1:0] rv = {i1.resp_valid, i0.resp_valid};

    calc_sched u_dut (.clk(clk), .rst(rst), .req0(i0), .req1(i1), .busy(busy));
    calc_sched #(.RR_EN(0)) u_fp (.clk(clk), .rst(rst), .req0(j0), .req1(j1), .busy(busy_fp));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s got %0d expected %0d", name, act, exp);
    endtask

    task automatic send(input int n, input calc_op_e o, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] er, input logic ec, input logic ee, input bit discard = 0);
        bit done = 0;
        op_d[n] = o;
        a_d[n] = a;
        b_d[n] = b;
        vld[n] = 1'b1;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (rdy[n]) begin
                done = 1;
                gseq.push_back(n);
                if (!discard) sb.push_back('{n, int'(er), int'(ec), int'(ee), cyc});
            end
        end
        if (!done) begin
            total++;
            $display("FAIL send_timeout req%0d got no ready expected ready within 60 cycles", n);
        end
        @(posedge clk);
        #1 vld[n] = 1'b0;
    endtask

    task automatic drain();
        bit done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !busy) done = 1;
        end
        if (!done) begin
            total++;
            $display("FAIL drain got %0d pending expected 0 within 100 cycles", sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    // monitor: pop the scoreboard whenever a response is consumed
    always @(negedge clk) begin
        exp_t e;
        if (rst) pv = 2'b00;
        else begin
            for (int n = 0; n < 2; n++) begin
                if (rv[n] && !pv[n]) vstart[n] = cyc;
                if (rv[n] && rr[n]) begin
                    if (sb.size() == 0) begin
                        total++;
                        $display("FAIL spurious_resp%0d got valid expected no response", n);
                    end else begin
                        e = sb.pop_front();
                        chk("resp_grant", n, e.idx);
                        chk("resp_result", int'(n != 0 ? i1.result : i0.result), e.res);
                        chk("resp_carry", int'(n != 0 ? i1.carry : i0.carry), e.car);
                        chk("resp_latency", vstart[n] - e.hs, 2);
                        chk("resp_other_valid", int'(rv[1-n]), 0);
`ifdef CALC_SCHED_DIV0_ERR_EN
                        chk("resp_err", int'(n != 0 ? i1.err : i0.err), e.err);
`endif
                    end
                end
            end
            pv = rv;
        end
    end

    initial begin
        int fg[$];
        op_d[0] = ADD;
        op_d[1] = ADD;
        a_d = '{4'd0, 4'd0};
        b_d = '{4'd0, 4'd0};
        vld[0] = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ready0", int'(i0.ready), 0);
        chk("rst_busy", int'(busy), 0);
        vld[0] = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_resp_valid", int'(rv), 0);
        chk("reset_result", int'(i0.result), 0);
        chk("reset_carry", int'(i0.carry), 0);
        @(posedge clk);
        #1;

        send(0, ADD, 4'd9, 4'd8, 4'h1, 1'b1, 1'b0);
        send(1, SUB, 4'd3, 4'd5, 4'hE, 1'b1, 1'b0);
        send(1, MUL, 4'd15, 4'd15, 4'h1, 1'b0, 1'b0);
        send(0, DIV, 4'd7, 4'd0, 4'hF, 1'b0, 1'b1);
        send(1, DIV, 4'd13, 4'd4, 4'h3, 1'b0, 1'b0);
        drain();

        gseq.delete();
        fork
            begin
                send(0, ADD, 4'd1, 4'd2, 4'h3, 1'b0, 1'b0);
                send(0, ADD, 4'd3, 4'd4, 4'h7, 1'b0, 1'b0);
            end
            begin
                send(1, ADD, 4'd5, 4'd6, 4'hB, 1'b0, 1'b0);
                send(1, ADD, 4'd7, 4'd8, 4'hF, 1'b0, 1'b0);
            end
        join
        drain();
        for (int k = 0; k < 4; k++) chk("rr_grant_order", k < gseq.size() ? gseq[k] : -1, k % 2);

        rr[0] = 1'b0;
        send(0, MUL, 4'd3, 4'd4, 4'hC, 1'b0, 1'b0);
        fork
            send(1, ADD, 4'd2, 4'd2, 4'h4, 1'b0, 1'b0);
            begin
                bit seen = 0;
                for (int i = 0; i < 10 && !seen; i++) begin
                    @(negedge clk);
                    seen = rv[0];
                end
                chk("hold_resp_seen", int'(seen), 1);
                for (int i = 0; i < 10; i++) begin
                    chk("hold_valid", int'(rv[0]), 1);
                    chk("hold_result", int'(i0.result), 12);
                    chk("hold_carry", int'(i0.carry), 0);
                    chk("hold_ready", int'(rdy), 0);
                    chk("hold_busy", int'(busy), 1);
                    @(negedge clk);
                end
                @(posedge clk);
                #1 rr[0] = 1'b1;
                @(negedge clk);
                @(negedge clk);
                chk("b2b_grant_ready1", int'(i1.ready), 1);
            end
        join
        drain();

        send(0, ADD, 4'd1, 4'd1, 4'h2, 1'b0, 1'b0, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_exec_ready", int'(rdy), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_exec_busy", int'(busy), 0);
        for (int i = 0; i < 4; i++) begin
            chk("rst_exec_no_resp", int'(rv), 0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        gseq.delete();
        fork
            send(0, SUB, 4'd9, 4'd2, 4'h7, 1'b0, 1'b0);
            send(1, ADD, 4'd1, 4'd1, 4'h2, 1'b0, 1'b0);
        join
        drain();
        chk("post_rst_first_grant", gseq.size() > 0 ? gseq[0] : -1, 0);
        chk("post_rst_second_grant", gseq.size() > 1 ? gseq[1] : -1, 1);

        vf = 2'b11;
        for (int i = 0; i < 60 && fg.size() < 3; i++) begin
            @(negedge clk);
            if (j0.ready || j1.ready) fg.push_back(int'(j1.ready));
        end
        vf = 2'b00;
        for (int k = 0; k < 3; k++) chk("fixed_grant", k < fg.size() ? fg[k] : -1, 0);

        chk("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
